dbg_req_arbiter: RTL and testbench

- Parametrised N-channel arbiter and router for the debug request/response port of the Rocket tile top.
- Lets several debug masters share the single core debug port: the JTAG DTM, a host-side UART bridge, and the PRM control plane.
- Round-robin grant, one transaction outstanding at a time, responses routed back to the requesting channel.
- Response timeout with error return and discard of the late response.

---
 rtl/dbg_req_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dbg_req_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dbg_req_arbiter.sv
// Round-robin arbiter/router sharing the core debug port among N_CH masters.
// One transaction in flight; a timed-out transaction returns resp=3 and its late core beat is drained.
module dbg_req_arbiter #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 34,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                     uncoreclk,
  input  logic                     uncorerst_n,
  input  logic [N_CH-1:0]          s_req_valid,
  output logic [N_CH-1:0]          s_req_ready,
  input  logic [N_CH*ADDR_W-1:0]   s_req_addr,
  input  logic [N_CH*2-1:0]        s_req_op,
  input  logic [N_CH*DATA_W-1:0]   s_req_data,
  output logic [N_CH-1:0]          s_resp_valid,
  input  logic [N_CH-1:0]          s_resp_ready,
  output logic [1:0]               s_resp_resp,
  output logic [DATA_W-1:0]        s_resp_data,
  output logic                     m_req_valid,
  input  logic                     m_req_ready,
  output logic [ADDR_W-1:0]        m_req_addr,
  output logic [1:0]               m_req_op,
  output logic [DATA_W-1:0]        m_req_data,
  input  logic                     m_resp_valid,
  output logic                     m_resp_ready,
  input  logic [1:0]               m_resp_resp,
  input  logic [DATA_W-1:0]        m_resp_data,
  output logic                     busy
);

  localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, REQ, RESP, RET, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [IW-1:0]       gnt_q, gnt_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          resp_q, resp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                drop_q, drop_d;

  logic                gnt_found;
  logic [IW-1:0]       gnt_idx;
  int unsigned         cand;

  // First requesting channel at or after the round-robin pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      cand = (32'(rr_q) + k) % N_CH;
      if (!gnt_found && s_req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    rdata_d = rdata_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          gnt_d   = gnt_idx;
          rr_d    = (gnt_idx == IW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
          addr_d  = s_req_addr[gnt_idx*ADDR_W +: ADDR_W];
          op_d    = s_req_op[gnt_idx*2 +: 2];
          wdata_d = s_req_data[gnt_idx*DATA_W +: DATA_W];
          state_d = REQ;
        end
      end
      REQ: begin
        if (m_req_ready) begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d = cnt_q + 1'b1;
        // A real response in the expiry cycle takes precedence over the timeout.
        if (m_resp_valid) begin
          resp_d  = m_resp_resp;
          rdata_d = m_resp_data;
          state_d = RET;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          resp_d  = 2'b11;
          rdata_d = '0;
          drop_d  = 1'b1;
          state_d = RET;
        end
      end
      RET: begin
        if (s_resp_ready[gnt_q]) state_d = drop_q ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (m_resp_valid) begin
          drop_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge uncoreclk or negedge uncorerst_n) begin
    if (!uncorerst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      op_q    <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      rdata_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    s_req_ready  = '0;
    s_resp_valid = '0;
    if (state_q == IDLE && gnt_found) s_req_ready[gnt_idx] = 1'b1;
    if (state_q == RET) s_resp_valid[gnt_q] = 1'b1;
  end

  assign m_req_valid  = (state_q == REQ);
  assign m_req_addr   = addr_q;
  assign m_req_op     = op_q;
  assign m_req_data   = wdata_q;
  assign m_resp_ready = (state_q == RESP) || (state_q == DRAIN);
  assign s_resp_resp  = resp_q;
  assign s_resp_data  = rdata_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_dbg_req_arbiter.sv
// Randomized bench for dbg_req_arbiter: transaction-level model predicts grants,
// core-port traffic and returned responses from timing arithmetic.
module tb_dbg_req_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 34;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
  logic [N*AW-1:0] s_req_addr;
  logic [N*2-1:0]  s_req_op;
  logic [N*DW-1:0] s_req_data;
  logic [1:0]      s_resp_resp, m_req_op, m_resp_resp;
  logic [DW-1:0]   s_resp_data, m_req_data, m_resp_data;
  logic [AW-1:0]   m_req_addr;
  logic            m_req_valid, m_req_ready, m_resp_valid, m_resp_ready, busy;

  always #5 clk = ~clk;

  dbg_req_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .uncoreclk(clk), .uncorerst_n(rst_n),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_addr(s_req_addr), .s_req_op(s_req_op), .s_req_data(s_req_data),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
    .s_resp_resp(s_resp_resp), .s_resp_data(s_resp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_addr(m_req_addr), .m_req_op(m_req_op), .m_req_data(m_req_data),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
    .m_resp_resp(m_resp_resp), .m_resp_data(m_resp_data),
    .busy(busy)
  );

  int unsigned n_vec = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Upstream masters
  logic          ch_v [N];
  logic [AW-1:0] ch_addr [N];
  logic [1:0]    ch_op [N];
  logic [DW-1:0] ch_data [N];

  // Core responder
  logic          core_act;
  int unsigned   core_start;
  logic [1:0]    core_resp;
  logic [DW-1:0] core_data;

  // Transaction-level reference
  typedef enum {M_FREE, M_ACC, M_WAIT, M_RET, M_DRAIN} mph_e;
  mph_e          ph;
  int            rr, cur;
  int unsigned   cyc = 0, ret_start;
  logic [AW-1:0] cap_addr;
  logic [1:0]    cap_op, exp_resp;
  logic [DW-1:0] cap_data, exp_data;
  logic          exp_drop;

  function automatic int unsigned pick_delay();
    int unsigned r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3, 4: return $urandom_range(1, 5);
      5:             return TO;
      6:             return TO + 1;
      7:             return TO + 30;
      default:       return $urandom_range(1, 20);
    endcase
  endfunction

  task automatic model_reset();
    ph = M_FREE; rr = 0; cur = 0; core_act = 1'b0; core_start = 0;
    for (int i = 0; i < N; i++) ch_v[i] = 1'b0;
  endtask

  task automatic do_reset();
    s_req_valid = '0; s_resp_ready = '0; s_req_addr = '0; s_req_op = '0; s_req_data = '0;
    m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_resp = '0; m_resp_data = '0;
    rst_n = 1'b0;
    #1;
    check("rst_s_req_ready", s_req_ready, 0);
    check("rst_s_resp_valid", s_resp_valid, 0);
    check("rst_s_resp_resp", s_resp_resp, 0);
    check("rst_s_resp_data", s_resp_data, 0);
    check("rst_m_req_valid", m_req_valid, 0);
    check("rst_m_req_fields", {m_req_addr, m_req_op, m_req_data}, 0);
    check("rst_m_resp_ready", m_resp_ready, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step();
    logic [N-1:0] exp_rdy, exp_sv;
    int           g;
    int unsigned  k;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!ch_v[i] && $urandom_range(0, 2) == 0) begin
        ch_v[i]    = 1'b1;
        ch_addr[i] = AW'($urandom);
        ch_op[i]   = 2'($urandom);
        ch_data[i] = {2'($urandom), 32'($urandom)};
      end
      s_req_valid[i]         = ch_v[i];
      s_req_addr[i*AW +: AW] = ch_addr[i];
      s_req_op[i*2 +: 2]     = ch_op[i];
      s_req_data[i*DW +: DW] = ch_data[i];
      s_resp_ready[i]        = ($urandom_range(0, 9) < 7);
    end
    m_req_ready  = ($urandom_range(0, 3) != 0);
    m_resp_valid = core_act && (cyc >= core_start);
    m_resp_resp  = core_resp;
    m_resp_data  = core_data;
    #1;

    if (ph == M_WAIT && cyc == ret_start) ph = M_RET;
    g = -1;
    if (ph == M_FREE)
      for (int j = 0; j < N; j++)
        if (g < 0 && ch_v[(rr + j) % N]) g = (rr + j) % N;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_sv = '0;
    if (ph == M_RET) exp_sv[cur] = 1'b1;

    check("s_req_ready", s_req_ready, exp_rdy);
    check("busy", busy, ph != M_FREE);
    check("m_req_valid", m_req_valid, ph == M_ACC);
    check("m_resp_ready", m_resp_ready, (ph == M_WAIT) || (ph == M_DRAIN));
    check("s_resp_valid", s_resp_valid, exp_sv);
    if (ph == M_ACC) check("m_req_fields", {m_req_addr, m_req_op, m_req_data}, {cap_addr, cap_op, cap_data});
    if (ph == M_RET) check("s_resp_payload", {s_resp_resp, s_resp_data}, {exp_resp, exp_data});

    case (ph)
      M_FREE: if (g >= 0) begin
        cur = g; cap_addr = ch_addr[g]; cap_op = ch_op[g]; cap_data = ch_data[g];
        rr = (g + 1) % N; ch_v[g] = 1'b0; ph = M_ACC;
      end
      M_ACC: if (m_req_ready) begin
        k          = pick_delay();
        core_act   = 1'b1;
        core_start = cyc + k;
        core_resp  = 2'($urandom_range(0, 2));
        core_data  = {2'($urandom), 32'($urandom)};
        if (k <= TO) begin
          exp_resp = core_resp; exp_data = core_data; exp_drop = 1'b0; ret_start = cyc + k + 1;
        end else begin
          exp_resp = 2'b11; exp_data = '0; exp_drop = 1'b1; ret_start = cyc + TO + 1;
        end
        ph = M_WAIT;
      end
      M_RET:   if (s_resp_ready[cur]) ph = exp_drop ? M_DRAIN : M_FREE;
      M_DRAIN: if (m_resp_valid) ph = M_FREE;
      default: ;
    endcase
    if (m_resp_valid && m_resp_ready) core_act = 1'b0;
    cyc++;
  endtask

  initial begin
    int unsigned guard;
    model_reset();
    #2;
    do_reset();
    repeat (3000) step();

    guard = 0;
    while (ph != M_WAIT && guard < 2000) begin
      step();
      guard++;
    end
    if (ph != M_WAIT) check("reach_resp_state", 0, 1);
    @(posedge clk);
    #2;
    check("pre_rst_busy", busy, 1);
    do_reset();
    repeat (3000) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
